onehot_dispatch_decoder: RTL and testbench
==========================================

Name: onehot_dispatch_decoder

Overview:
- Consumer end of an 8-input priority encoder interface: takes an encoded index plus NONE flag over a valid/ready handshake.
- Decodes the index back to a one-hot grant, holds it until the serviced line signals done or a timeout expires, then accepts the next request.
- Sits between the request priority encoder and the per-line handler logic; tracks completed services.

Parameters:
- N_SEL, 3, index width; grant width is 2**N_SEL (8 by default).
- TIMEOUT, 15, maximum cycles grant is held awaiting done; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present on in_idx/in_none.
- in_ready  output  1  block can accept a request this cycle.
- in_idx  input  N_SEL  encoded index of highest-priority active line.
- in_none  input  1  no line active; in_idx is ignored.
- grant  output  2**N_SEL  one-hot grant to the serviced line; all-zero when idle.
- grant_valid  output  1  a grant is active.
- done  input  1  handler of the granted line finished.
- timeout_err  output  1  one-cycle pulse: grant expired without done.
- last_idx  output  N_SEL  index of the most recently accepted non-NONE request.
- serviced_cnt  output  8  count of grants ended by done; saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, grant=0, grant_valid=0, timeout_err=0, last_idx=0, serviced_cnt=0, timer=0.
- In-reset behaviour: in_ready=0 while rst_n is low; it rises in the first cycle after release.
- States:
  - IDLE: in_ready=1.
  - ACTIVE: in_ready=0, grant_valid=1.
- All outputs except in_ready are registered; in_ready is decoded from the state.
- Handshake: a transfer occurs on a rising edge where in_valid and in_ready are both 1.
- NONE transfer in IDLE (in_none=1): request is consumed and dropped; state stays IDLE; no output changes.
- Non-NONE transfer in IDLE:
  - On the same edge: state becomes ACTIVE, grant = 1 << in_idx, last_idx = in_idx, timer = 0.
  - Latency: grant is visible in the cycle immediately after the handshake.
- ACTIVE, each rising edge:
  - done=1: state becomes IDLE, grant=0, grant_valid=0, serviced_cnt increments (holds at 255).
  - Else, if timer == TIMEOUT-1: state becomes IDLE, grant=0, timeout_err=1 for exactly one cycle, serviced_cnt unchanged.
  - Else: timer increments.
  - Grant therefore stays high for at most TIMEOUT cycles.
- Simultaneous done and timeout on the same edge: done wins, so count increments and there is no error pulse.
- done while IDLE: ignored.
- in_valid while ACTIVE: not accepted (in_ready=0); the upstream source must hold the request.
- Back-to-back requests: the state returns to IDLE on the completing edge, so in_ready=1 the next cycle.
  - Minimum request spacing is therefore 2 cycles: handshake, then ≥1 ACTIVE cycle.
- grant is always zero or exactly one-hot.
- grant_valid equals (state==ACTIVE).
- Reset mid-ACTIVE: grant drops immediately (asynchronous) and the pending service is discarded.
- Width rules:
  - timer is 8 bits.
  - in_idx is treated as unsigned.
  - With default N_SEL, all 8 index values are legal.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run, release, hold 3 cycles -> grant=0, grant_valid=0, in_ready=1, serviced_cnt=0, timeout_err=0.
- Basic service: in_idx=5, in_none=0, in_valid=1 for one cycle; done=1 on the 3rd ACTIVE cycle -> grant=8'b0010_0000 for 3 cycles, last_idx=5, serviced_cnt=1, in_ready=1 the cycle after.
- NONE drop: in_none=1, in_idx=7, in_valid=1 for 4 cycles -> in_ready stays 1, grant stays 0, last_idx and serviced_cnt unchanged.
- Timeout and tie:
  - TIMEOUT=15, in_idx=0, done never asserted -> grant=8'b0000_0001 for exactly 15 cycles, then timeout_err high for 1 cycle, serviced_cnt unchanged.
  - Repeat with done=1 in grant cycle 15 -> no error pulse, serviced_cnt +1.
- Back-to-back with stall:
  - in_valid held high with in_idx=3 then 6 while ACTIVE -> second request accepted only after done; grants 8'h08 then 8'h40.
  - Upstream holds in_idx=6 while in_ready=0.
  - done asserted in IDLE is ignored.
- Saturation/reset-abort:
  - 260 serviced requests -> serviced_cnt=255.
  - rst_n low during ACTIVE grant 8'h80 -> grant=0 immediately, serviced_cnt=0.

Source files
------------

// File: rtl/onehot_dispatch_decoder.sv
// Consumer side of a priority-encoder link: decodes an accepted index to a one-hot grant,
// holds it until done or timeout, and counts services completed by done.
module onehot_dispatch_decoder #(
  parameter int unsigned N_SEL   = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_SEL-1:0]      in_idx,
  input  logic                  in_none,
  output logic [2**N_SEL-1:0]   grant,
  output logic                  grant_valid,
  input  logic                  done,
  output logic                  timeout_err,
  output logic [N_SEL-1:0]      last_idx,
  output logic [7:0]            serviced_cnt
);

  localparam int unsigned NumLines  = 2**N_SEL;
  localparam logic [7:0]  TimerLast = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e              state_q, state_d;
  logic [NumLines-1:0] grant_q, grant_d;
  logic [N_SEL-1:0]    last_idx_q, last_idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          timer_q, timer_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_idx_q <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // NONE requests are consumed without touching any state
        if (in_valid && in_ready && !in_none) begin
          state_d         = StActive;
          grant_d         = '0;
          grant_d[in_idx] = 1'b1;
          last_idx_d      = in_idx;
          timer_d         = '0;
        end
      end
      StActive: begin
        // done takes precedence over an expiry on the same edge
        if (done) begin
          state_d = StIdle;
          grant_d = '0;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (timer_q == TimerLast) begin
          state_d = StIdle;
          grant_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready     = rst_n && (state_q == StIdle);
    grant_valid  = (state_q == StActive);
    grant        = grant_q;
    timeout_err  = err_q;
    last_idx     = last_idx_q;
    serviced_cnt = cnt_q;
  end

endmodule

// File: tb/tb_onehot_dispatch_decoder.sv
// Bench for onehot_dispatch_decoder: directed scenarios with literal expectations plus a
// cycle-level service model compared against the DUT on every falling edge.
module tb_onehot_dispatch_decoder;

  localparam int unsigned N_SEL   = 3;
  localparam int unsigned TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_idx = '0;
  logic       in_none = 1'b0;
  logic [7:0] grant;
  logic       grant_valid;
  logic       done = 1'b0;
  logic       timeout_err;
  logic [2:0] last_idx;
  logic [7:0] serviced_cnt;

  int checks = 0;
  int errors = 0;

  onehot_dispatch_decoder #(
    .N_SEL  (N_SEL),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
    .in_none     (in_none),
    .grant       (grant),
    .grant_valid (grant_valid),
    .done        (done),
    .timeout_err (timeout_err),
    .last_idx    (last_idx),
    .serviced_cnt(serviced_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Service model: a grant lives for m_held cycles (1-based), ends on done or after TIMEOUT.
  int m_active = 0;
  int m_idx    = 0;
  int m_held   = 0;
  int m_cnt    = 0;
  int m_last   = 0;
  int m_err    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0;
      m_idx    <= 0;
      m_held   <= 0;
      m_cnt    <= 0;
      m_last   <= 0;
      m_err    <= 0;
    end else begin
      m_err <= 0;
      if (m_active != 0) begin
        if (done) begin
          m_active <= 0;
          if (m_cnt < 255) m_cnt <= m_cnt + 1;
        end else if (m_held == int'(TIMEOUT)) begin
          m_active <= 0;
          m_err    <= 1;
        end else begin
          m_held <= m_held + 1;
        end
      end else if (in_valid && !in_none) begin
        m_active <= 1;
        m_idx    <= int'(in_idx);
        m_last   <= int'(in_idx);
        m_held   <= 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_grant", int'(grant), (m_active != 0) ? (1 << m_idx) : 0);
    check("cmp_grant_valid", int'(grant_valid), m_active);
    check("cmp_in_ready", int'(in_ready), (rst_n && m_active == 0) ? 1 : 0);
    check("cmp_timeout_err", int'(timeout_err), m_err);
    check("cmp_last_idx", int'(last_idx), m_last);
    check("cmp_serviced_cnt", int'(serviced_cnt), m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int held;
  int cnt0;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Reset asserted mid-run, then three idle cycles
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("rst_grant", int'(grant), 0);
    check("rst_grant_valid", int'(grant_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_cnt", int'(serviced_cnt), 0);
    check("rst_err", int'(timeout_err), 0);

    // Basic service, done on the third active cycle
    in_valid = 1'b1; in_idx = 3'd5; in_none = 1'b0;
    step();
    in_valid = 1'b0;
    check("basic_grant_c1", int'(grant), 8'h20);
    check("basic_last_idx", int'(last_idx), 5);
    check("basic_ready_c1", int'(in_ready), 0);
    step();
    check("basic_grant_c2", int'(grant), 8'h20);
    step();
    check("basic_grant_c3", int'(grant), 8'h20);
    done = 1'b1;
    step();
    done = 1'b0;
    check("basic_grant_end", int'(grant), 0);
    check("basic_cnt", int'(serviced_cnt), 1);
    check("basic_ready_end", int'(in_ready), 1);

    // NONE requests are dropped
    in_valid = 1'b1; in_idx = 3'd7; in_none = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("none_ready", int'(in_ready), 1);
      check("none_grant", int'(grant), 0);
    end
    in_valid = 1'b0; in_none = 1'b0;
    check("none_last_idx", int'(last_idx), 5);
    check("none_cnt", int'(serviced_cnt), 1);

    // Timeout: grant for exactly TIMEOUT cycles, then one error pulse
    cnt0 = int'(serviced_cnt);
    in_valid = 1'b1; in_idx = 3'd0;
    step();
    in_valid = 1'b0;
    held = 0;
    for (int k = 0; k < 40 && grant == 8'h01; k++) begin
      held++;
      step();
    end
    check("to_held", held, 15);
    check("to_err_pulse", int'(timeout_err), 1);
    check("to_grant_off", int'(grant), 0);
    check("to_cnt", int'(serviced_cnt), cnt0);
    step();
    check("to_err_clear", int'(timeout_err), 0);

    // done in grant cycle 15 beats the timeout
    in_valid = 1'b1; in_idx = 3'd0;
    step();
    in_valid = 1'b0;
    repeat (14) step();
    check("tie_grant_c15", int'(grant), 8'h01);
    done = 1'b1;
    step();
    done = 1'b0;
    check("tie_grant_off", int'(grant), 0);
    check("tie_err", int'(timeout_err), 0);
    check("tie_cnt", int'(serviced_cnt), cnt0 + 1);

    // Back-to-back with upstream stall
    in_valid = 1'b1; in_idx = 3'd3;
    step();
    in_idx = 3'd6;
    check("b2b_grant_a", int'(grant), 8'h08);
    check("b2b_ready_a", int'(in_ready), 0);
    step();
    check("b2b_grant_stall", int'(grant), 8'h08);
    done = 1'b1;
    step();
    done = 1'b0;
    check("b2b_idle_grant", int'(grant), 0);
    check("b2b_idle_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("b2b_grant_b", int'(grant), 8'h40);
    check("b2b_last_idx", int'(last_idx), 6);
    done = 1'b1;
    step();
    cnt0 = int'(serviced_cnt);
    step();
    step();
    done = 1'b0;
    check("idle_done_cnt", int'(serviced_cnt), cnt0);
    check("idle_done_grant", int'(grant), 0);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      in_valid = 1'b1; in_idx = 3'(i % 8);
      step();
      in_valid = 1'b0; done = 1'b1;
      step();
      done = 1'b0;
    end
    check("sat_cnt", int'(serviced_cnt), 255);

    // Reset during an active grant
    in_valid = 1'b1; in_idx = 3'd7;
    step();
    in_valid = 1'b0;
    check("abort_grant_pre", int'(grant), 8'h80);
    rst_n = 1'b0;
    #1;
    check("abort_grant", int'(grant), 0);
    check("abort_cnt", int'(serviced_cnt), 0);
    check("abort_ready", int'(in_ready), 0);
    check("abort_grant_valid", int'(grant_valid), 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("abort_ready_after", int'(in_ready), 1);
    check("abort_last_idx", int'(last_idx), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
